// File: rtl/pipe_credit_buffer_pkg.sv
// Shared defaults and helpers for the credit-gated elastic output stage.
package pipe_credit_buffer_pkg;

   localparam int PCB_BITS_DEF  = 16;
   localparam int PCB_DEPTH_DEF = 8;

   // Pointer width for a DEPTH-entry ring; never zero so DEPTH=1 still has a legal index.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/delay_n.sv
// Fixed-latency delay line: the word presented at cycle t appears on o_q at cycle t+N.
module delay_n #(
   parameter int N    = 4,
   parameter int BITS = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic [BITS-1:0] i_d,
   output logic [BITS-1:0] o_q
);

   logic [BITS-1:0] stage_q [N];

   // Shift register; reset flushes every stage so no stale tag survives a restart.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N; i++) stage_q[i] <= '0;
      end else if (i_en) begin
         stage_q[0] <= i_d;
         for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign o_q = stage_q[N-1];

endmodule

// File: rtl/pipe_credit_buffer_fifo.sv
// Synchronous FIFO core: storage, wrapping pointers and occupancy for any DEPTH >= 1.
// The caller qualifies i_push/i_pop (no push when full without a pop, no pop when empty).
module sync_fifo_core
   import pipe_credit_buffer_pkg::*;
#(
   parameter  int BITS  = PCB_BITS_DEF,
   parameter  int DEPTH = PCB_DEPTH_DEF,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic [BITS-1:0] i_data,
   input  logic            i_pop,
   output logic [BITS-1:0] o_data,
   output logic [CW-1:0]   o_occ,
   output logic            o_full,
   output logic            o_empty
);

   logic [BITS-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   occ_q, occ_d;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths never touch unused indices.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next-state for pointers and occupancy; simultaneous push and pop leaves occupancy alone.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (i_push) wr_ptr_d = ptr_next(wr_ptr_q);
      if (i_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
      case ({i_push, i_pop})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control state register; storage below is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage write.
   always_ff @(posedge i_clk) begin
      if (i_push) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_occ   = occ_q;
   assign o_full  = (occ_q == CW'(DEPTH));
   assign o_empty = (occ_q == '0);

endmodule

// File: rtl/pipe_credit_buffer.sv
// Credit-gated elastic stage behind a non-stalling pipeline: an issue is allowed only
// when the words already buffered plus those still in flight leave a free FIFO slot.
module pipe_credit_buffer
   import pipe_credit_buffer_pkg::*;
#(
   parameter  int BITS  = PCB_BITS_DEF,
   parameter  int DEPTH = PCB_DEPTH_DEF,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   output logic            o_issue,
   input  logic            i_pipe_valid,
   input  logic [BITS-1:0] i_pipe_data,
   output logic            o_out_valid,
   output logic [BITS-1:0] o_out_data,
   input  logic            i_out_ready,
   output logic [CW-1:0]   o_occ,
   output logic            o_err
);

   logic [CW-1:0] inflight_q, inflight_d;
   logic          err_q, err_d;
   logic [CW-1:0] occ;
   logic [CW:0]   credit_used;
   logic          full, empty, pop, push, ret, spurious, overflow;

   // Credit check uses registered counts only, so a pop frees its credit one cycle later.
   assign credit_used = {1'b0, occ} + {1'b0, inflight_q};
   assign o_in_ready  = (credit_used < (CW+1)'(DEPTH));
   assign o_issue     = i_in_valid & o_in_ready;

   assign o_out_valid = ~empty;
   assign pop         = o_out_valid & i_out_ready;

   // A return with nothing in flight is dropped; a return into a full FIFO without a pop
   // still consumes its credit but the word is lost.
   assign spurious    = i_pipe_valid & (inflight_q == '0);
   assign ret         = i_pipe_valid & ~spurious;
   assign overflow    = ret & full & ~pop;
   assign push        = ret & ~overflow;

   sync_fifo_core #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (i_pipe_data),
      .i_pop   (pop),
      .o_data  (o_out_data),
      .o_occ   (occ),
      .o_full  (full),
      .o_empty (empty)
   );

   // In-flight count and sticky error next-state.
   always_comb begin
      inflight_d = inflight_q;
      err_d      = err_q | spurious | overflow;
      case ({o_issue, ret})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Control registers; reset forgets every outstanding credit.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign o_occ = occ;
   assign o_err = err_q;

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// Bench for pipe_credit_buffer: DEPTH=8/LAT=4 instance checked every cycle against a
// queue-based model, plus a DEPTH=5/LAT=3 instance checked with an order scoreboard.
module tb_pipe_credit_buffer;

   localparam int DEPTH  = 8;
   localparam int LAT    = 4;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int DEPTH2 = 5;
   localparam int LAT2   = 3;
   localparam int CW2    = $clog2(DEPTH2 + 1);

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- main instance ----------------
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [15:0]   in_data = '0;
   logic          inj_valid = 1'b0;
   logic [15:0]   inj_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, issue, out_valid, err;
   logic [15:0]   out_data;
   logic [CW-1:0] occ;
   logic          dl_valid;
   logic [15:0]   dl_data;
   logic          pipe_valid;
   logic [15:0]   pipe_data;

   assign pipe_valid = dl_valid | inj_valid;
   assign pipe_data  = inj_valid ? inj_data : dl_data;

   delay_n #(.N(LAT), .BITS(1))  u_dl_tag  (.i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1), .i_d(issue),   .o_q(dl_valid));
   delay_n #(.N(LAT), .BITS(16)) u_dl_data (.i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1), .i_d(in_data), .o_q(dl_data));

   pipe_credit_buffer #(.BITS(16), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .o_issue(issue),
      .i_pipe_valid(pipe_valid), .i_pipe_data(pipe_data),
      .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
      .o_occ(occ), .o_err(err)
   );

   // Behavioural model: FIFO contents as a queue, outstanding issues as a plain count.
   logic [15:0] mq[$];
   int          mi = 0;
   bit          me = 0;
   bit          model_on = 0;
   bit          seen_dead = 0;
   bit          m_pop, m_iss, m_ret, m_full;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         mi = 0;
         me = 0;
      end else begin
         m_pop  = (mq.size() > 0) && out_ready;
         m_iss  = in_valid && ((mq.size() + mi) < DEPTH);
         m_ret  = pipe_valid && (mi > 0);
         m_full = (mq.size() == DEPTH);
         if (pipe_valid && mi == 0) me = 1;
         if (m_pop) void'(mq.pop_front());
         if (m_ret) begin
            if (m_full && !m_pop) me = 1;
            else mq.push_back(pipe_data);
         end
         mi = mi + int'(m_iss) - int'(m_ret);
      end
   end

   // Every-cycle comparison of the DUT against the model, mid-cycle.
   always @(negedge clk) begin
      if (model_on) begin
         chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
         if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
         chk("occ", 32'(occ), 32'(mq.size()));
         chk("in_ready", 32'(in_ready), 32'((mq.size() + mi) < DEPTH));
         chk("issue", 32'(issue), 32'(in_valid && ((mq.size() + mi) < DEPTH)));
         chk("err", 32'(err), 32'(me));
         if (out_valid && out_data == 16'hDEAD) seen_dead = 1;
      end
   end

   // ---------------- DEPTH=5 instance ----------------
   logic           rst2_n = 1'b0;
   logic           in_valid2 = 1'b0;
   logic [15:0]    in_data2 = '0;
   logic           out_ready2 = 1'b0;
   logic           in_ready2, issue2, out_valid2, err2;
   logic [15:0]    out_data2;
   logic [CW2-1:0] occ2;
   logic           dl_valid2;
   logic [15:0]    dl_data2;
   bit             done2 = 0;

   delay_n #(.N(LAT2), .BITS(1))  u_dl_tag2  (.i_clk(clk), .i_rst_n(rst2_n), .i_en(1'b1), .i_d(issue2),   .o_q(dl_valid2));
   delay_n #(.N(LAT2), .BITS(16)) u_dl_data2 (.i_clk(clk), .i_rst_n(rst2_n), .i_en(1'b1), .i_d(in_data2), .o_q(dl_data2));

   pipe_credit_buffer #(.BITS(16), .DEPTH(DEPTH2)) dut2 (
      .i_clk(clk), .i_rst_n(rst2_n),
      .i_in_valid(in_valid2), .o_in_ready(in_ready2), .o_issue(issue2),
      .i_pipe_valid(dl_valid2), .i_pipe_data(dl_data2),
      .o_out_valid(out_valid2), .o_out_data(out_data2), .i_out_ready(out_ready2),
      .o_occ(occ2), .o_err(err2)
   );

   initial begin
      logic [15:0] exp2[$];
      int issued;
      int accepted;
      issued   = 0;
      accepted = 0;
      step();
      step();
      rst2_n = 1'b1;
      for (int c = 0; c < 2000 && accepted < 23; c++) begin
         in_valid2  = (issued < 23) && ($urandom_range(0, 3) != 0);
         in_data2   = 16'($urandom) & 16'h7FFF;
         out_ready2 = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (issue2) begin
            exp2.push_back(in_data2);
            issued++;
         end
         if (out_valid2 && out_ready2) begin
            if (exp2.size() == 0) chk("d5_extra_word", 32'(out_data2), 32'hFFFF_FFFF);
            else chk("d5_order", 32'(out_data2), 32'(exp2.pop_front()));
            accepted++;
         end
         chk("d5_occ_bound", 32'(occ2 <= CW2'(DEPTH2)), 32'd1);
         step();
      end
      in_valid2 = 1'b0;
      chk("d5_count", 32'(accepted), 32'd23);
      chk("d5_err", 32'(err2), 32'd0);
      done2 = 1;
   end

   // ---------------- main stimulus ----------------
   initial begin
      int n;
      int cnt;
      int k;
      int first;
      int nout;
      bit resumed;
      bit bad;

      // Reset state
      step();
      step();
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_err", 32'(err), 32'd0);
      rst_n    = 1'b1;
      model_on = 1;

      // Fill with backpressure: exactly DEPTH issues, occupancy 8 at cycle 12
      n = 0;
      cnt = 0;
      for (int c = 0; c < 16; c++) begin
         in_valid = 1'b1;
         in_data = 16'(n);
         out_ready = 1'b0;
         @(negedge clk);
         if (issue) begin cnt++; n++; end
         if (c == 7)  chk("fill_ready_c7", 32'(in_ready), 32'd1);
         if (c == 8)  chk("fill_ready_c8", 32'(in_ready), 32'd0);
         if (c == 11) chk("fill_occ_c11", 32'(occ), 32'd7);
         if (c == 12) chk("fill_occ_c12", 32'(occ), 32'd8);
         step();
      end
      chk("fill_issues", 32'(cnt), 32'd8);
      k = 0;
      resumed = 0;
      for (int c = 0; c < 20; c++) begin
         in_data = 16'(n);
         out_ready = 1'b1;
         @(negedge clk);
         if (issue) begin resumed = 1; n++; end
         if (out_valid && k < 8) begin
            chk("fill_order", 32'(out_data), 32'(k));
            k++;
         end
         step();
      end
      chk("fill_drained", 32'(k), 32'd8);
      chk("fill_resume", 32'(resumed), 32'd1);
      in_valid = 1'b0;
      for (int c = 0; c < 12; c++) step();

      // Streaming: first output at cycle 5 carrying 0x0001, then one word per cycle
      n = 1;
      first = -1;
      nout = 0;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         in_valid = 1'b1;
         in_data = 16'(n);
         out_ready = 1'b1;
         @(negedge clk);
         if (issue) n++;
         if (out_valid) begin
            if (first < 0) begin
               chk("stream_first_cyc", 32'(c), 32'd5);
               chk("stream_first_data", 32'(out_data), 32'h0001);
               first = c;
            end
            chk("stream_data", 32'(out_data), 32'(c - 4));
            nout++;
         end
         if (occ > 1 || !in_ready) bad = 1;
         step();
      end
      chk("stream_throughput", 32'(nout), 32'd25);
      chk("stream_occ_ready", 32'(bad), 32'd0);
      in_valid = 1'b0;
      for (int c = 0; c < 10; c++) step();

      // Spurious return with nothing in flight
      inj_valid = 1'b1;
      inj_data = 16'hDEAD;
      step();
      inj_valid = 1'b0;
      @(negedge clk);
      chk("spur_err", 32'(err), 32'd1);
      chk("spur_occ", 32'(occ), 32'd0);
      step();
      for (int c = 0; c < 5; c++) step();
      chk("spur_err_sticky", 32'(err), 32'd1);
      chk("spur_never_dead", 32'(seen_dead), 32'd0);

      // Reset mid-stream with occupancy 3 and two words in flight
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         in_valid = (c < 5);
         in_data = 16'h0100 + 16'(c);
         step();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_occ3", 32'(occ), 32'd3);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_occ", 32'(occ), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_err", 32'(err), 32'd0);
      step();
      for (int c = 0; c < 40; c++) begin
         in_valid = 1'b1;
         in_data = 16'($urandom) & 16'h7FFF;
         out_ready = 1'b1;
         step();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 10; c++) step();
      chk("post_rst_err", 32'(err), 32'd0);

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = 16'($urandom) & 16'h7FFF;
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) step();
      chk("final_err", 32'(err), 32'd0);
      chk("final_empty", 32'(out_valid), 32'd0);

      for (int i = 0; i < 3000 && !done2; i++) step();
      if (!done2) chk("d5_timeout", 32'd0, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
